// File: rtl/ddr3_wr_pkg.sv
// Shared constants for the DDR3 write-burst scheduler: FSM encoding,
// AXI response codes and the bytes-per-beat helper.
package ddr3_wr_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] AW   = 2'd1;
   localparam logic [1:0] W    = 2'd2;
   localparam logic [1:0] B    = 2'd3;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   function automatic int beat_bytes(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/ddr3_wr_skid2.sv
// Two-entry registered skid buffer between the FIFO read port and the AXI
// write data channel; head is the oldest entry.
module ddr3_wr_skid2
   import ddr3_wr_pkg::*;
#(
   parameter int DATA_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [1:0]            count
);

   logic [DATA_WIDTH-1:0] slot0;
   logic [DATA_WIDTH-1:0] slot1;

   always_ff @(posedge clk) begin
      if (!rstn) count <= 2'd0;
      else       count <= count + {1'b0, push} - {1'b0, pop};
   end

   // Simultaneous push/pop with one entry lands the new word straight in the head.
   always_ff @(posedge clk) begin
      if (pop) begin
         slot0 <= (push && count == 2'd1) ? push_data : slot1;
         if (push) slot1 <= push_data;
      end else if (push) begin
         if (count == 2'd0) slot0 <= push_data;
         else               slot1 <= push_data;
      end
   end

   assign head = slot0;

endmodule

// File: rtl/ddr3_wr_burst_sched.sv
// Drains the DDR3 write FIFO into AXI4 write bursts over a ring-buffer
// region; one burst outstanding at a time (AW, then W, then B).
module ddr3_wr_burst_sched
   import ddr3_wr_pkg::*;
#(
   parameter int              DATA_WIDTH   = 256,
   parameter int              LEVEL_WIDTH  = 11,
   parameter int              ADDR_WIDTH   = 28,
   parameter int              BURST_LEN    = 16,
   parameter longint unsigned BASE_ADDR    = 64'd0,
   parameter longint unsigned REGION_BYTES = 64'd16777216
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   enable,
   input  logic                   flush,
   input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
   input  logic                   fifo_rd_empty,
   input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
   output logic                   fifo_rd_en,
   output logic [ADDR_WIDTH-1:0]  awaddr,
   output logic [7:0]             awlen,
   output logic                   awvalid,
   input  logic                   awready,
   output logic [DATA_WIDTH-1:0]  wdata,
   output logic                   wlast,
   output logic                   wvalid,
   input  logic                   wready,
   input  logic [1:0]             bresp,
   input  logic                   bvalid,
   output logic                   bready,
   output logic                   busy,
   output logic                   resp_err,
   output logic [31:0]            burst_cnt
);

   localparam int                     BYTES      = beat_bytes(DATA_WIDTH);
   localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(BURST_LEN);
   localparam logic [ADDR_WIDTH:0]    REGION_END = (ADDR_WIDTH+1)'(BASE_ADDR + REGION_BYTES);
   localparam logic [ADDR_WIDTH-1:0]  BASE       = ADDR_WIDTH'(BASE_ADDR);

   logic [1:0]            state;
   logic [8:0]            beats;
   logic [8:0]            popped;
   logic [8:0]            sent;
   logic                  rd_pend;
   logic [1:0]            sk_count;
   logic [DATA_WIDTH-1:0] sk_head;
   logic                  sk_pop;
   logic [2:0]            occ;
   logic                  start_full;
   logic                  start_flush;
   logic                  launch;
   logic [ADDR_WIDTH:0]   addr_sum;

   assign start_full  = fifo_rd_level >= FULL_LEVEL;
   assign start_flush = flush && (fifo_rd_level != '0) && !fifo_rd_empty;
   assign launch      = (state == IDLE) && enable && (start_full || start_flush);

   assign wvalid = sk_count != 2'd0;
   assign wdata  = sk_head;
   assign sk_pop = wvalid && wready;
   assign wlast  = wvalid && (sent == beats - 9'd1);

   // Slots committed after this cycle: held + in flight - leaving now; the
   // pop credit is what lets back-to-back beats stream at one per cycle.
   assign occ        = {1'b0, sk_count} + {2'b0, rd_pend} - {2'b0, sk_pop};
   assign fifo_rd_en = (state == W) && (popped < beats) && (occ < 3'd2) && !fifo_rd_empty;

   assign awvalid = state == AW;
   assign awlen   = 8'(beats - 9'd1);
   assign bready  = state == B;
   assign busy    = state != IDLE;

   assign addr_sum = {1'b0, awaddr} + (ADDR_WIDTH+1)'(beats) * (ADDR_WIDTH+1)'(BYTES);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         beats     <= 9'd1;
         popped    <= 9'd0;
         sent      <= 9'd0;
         rd_pend   <= 1'b0;
         awaddr    <= BASE;
         resp_err  <= 1'b0;
         burst_cnt <= 32'd0;
      end else begin
         rd_pend <= fifo_rd_en;
         case (state)
            IDLE: if (launch) begin
               beats <= start_full ? 9'(BURST_LEN) : 9'(fifo_rd_level);
               state <= AW;
            end
            AW: if (awready) begin
               popped <= 9'd0;
               sent   <= 9'd0;
               state  <= W;
            end
            W: begin
               if (fifo_rd_en) popped <= popped + 9'd1;
               if (sk_pop) begin
                  sent <= sent + 9'd1;
                  if (wlast) state <= B;
               end
            end
            B: if (bvalid) begin
               resp_err  <= resp_err | (bresp != OKAY);
               burst_cnt <= burst_cnt + 32'd1;
               awaddr    <= (addr_sum >= REGION_END) ? BASE : addr_sum[ADDR_WIDTH-1:0];
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   ddr3_wr_skid2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk       (clk),
      .rstn      (rstn),
      .push      (rd_pend),
      .push_data (fifo_rd_data),
      .pop       (sk_pop),
      .head      (sk_head),
      .count     (sk_count)
   );

endmodule

// File: tb/tb_ddr3_wr_burst_sched.sv
// Randomized bench: FIFO, AXI slave and a burst-level reference model feed a
// scoreboard that a negedge monitor drains as the DUT handshakes.
module tb_ddr3_wr_burst_sched;

   localparam int DW = 256, LW = 11, AWD = 28, BL = 16, REGION = 1024, BEAT = DW / 8;

   logic           clk = 1'b0;
   logic           rstn, enable, flush;
   logic [LW-1:0]  fifo_rd_level;
   logic           fifo_rd_empty;
   logic [DW-1:0]  fifo_rd_data;
   logic           fifo_rd_en;
   logic [AWD-1:0] awaddr;
   logic [7:0]     awlen;
   logic           awvalid, awready;
   logic [DW-1:0]  wdata;
   logic           wlast, wvalid, wready;
   logic [1:0]     bresp;
   logic           bvalid, bready, busy, resp_err;
   logic [31:0]    burst_cnt;

   always #5 clk = ~clk;

   ddr3_wr_burst_sched #(
      .DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .ADDR_WIDTH(AWD), .BURST_LEN(BL),
      .BASE_ADDR(64'd0), .REGION_BYTES(64'd1024)
   ) dut (
      .clk(clk), .rstn(rstn), .enable(enable), .flush(flush),
      .fifo_rd_level(fifo_rd_level), .fifo_rd_empty(fifo_rd_empty),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
      .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .busy(busy), .resp_err(resp_err), .burst_cnt(burst_cnt)
   );

   typedef struct { logic [AWD-1:0] addr; logic [7:0] len; } aw_t;
   typedef struct { logic [DW-1:0] data; logic last; } w_t;

   aw_t           exp_aw[$];
   w_t            exp_w[$];
   logic [1:0]    resp_q[$];
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] in_q[$];

   int vectors = 0, errors = 0;
   int model_addr = 0, exp_cnt = 0, beats_seen = 0, stall_left = 0;
   bit exp_err = 0, aw_done = 0, chk_after = 0, b_pending = 0, b_hs = 0, stall_mode = 0;
   logic rd_en_s = 1'b0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      vectors++;
      errors++;
      $display("FAIL %s: bound expired or no expectation", nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // FIFO model: registered read data, level/empty reflect pops already taken.
   always @(negedge clk) rd_en_s = fifo_rd_en;
   initial begin
      fifo_rd_data  = '0;
      fifo_rd_level = '0;
      fifo_rd_empty = 1'b1;
      forever begin
         tick();
         if (rd_en_s && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
         while (in_q.size() > 0) fifo_q.push_back(in_q.pop_front());
         fifo_rd_level = LW'(fifo_q.size());
         fifo_rd_empty = fifo_q.size() == 0;
      end
   end

   initial begin
      awready = 1'b0;
      forever begin
         tick();
         awready = $urandom_range(0, 2) != 0;
      end
   end

   initial begin
      wready = 1'b0;
      forever begin
         tick();
         if (stall_left > 0) begin
            wready = 1'b0;
            stall_left--;
         end else begin
            wready = 1'b1;
            if (stall_mode && $urandom_range(0, 1) == 1) stall_left = $urandom_range(0, 3);
         end
      end
   end

   initial begin
      bvalid = 1'b0;
      bresp  = 2'b00;
      forever begin
         tick();
         if (!rstn) begin
            bvalid = 1'b0; b_pending = 0; b_hs = 0;
         end else if (b_hs) begin
            bvalid = 1'b0; b_hs = 0;
         end else if (b_pending && !bvalid && $urandom_range(0, 1) == 1) begin
            bvalid = 1'b1;
            bresp  = resp_q.size() > 0 ? resp_q.pop_front() : 2'b00;
            b_pending = 0;
         end
      end
   end

   // Monitor: pops the scoreboard on every handshake the DUT completes.
   always @(negedge clk) begin
      aw_t a;
      w_t  w;
      if (!rstn) begin
         aw_done   = 0;
         chk_after = 0;
      end else begin
         if (chk_after) begin
            chk("burst_cnt", burst_cnt, exp_cnt);
            chk("resp_err", resp_err, exp_err);
            chk_after = 0;
         end
         if (fifo_rd_en) chk("rd_en_nonempty", fifo_rd_empty, 0);
         if (wvalid) chk("w_after_aw", aw_done, 1);
         if (awvalid && awready) begin
            if (exp_aw.size() == 0) fail_now("unexpected_aw");
            else begin
               a = exp_aw.pop_front();
               chk("awaddr", awaddr, a.addr);
               chk("awlen", awlen, a.len);
            end
            aw_done = 1;
         end
         if (wvalid && wready) begin
            if (exp_w.size() == 0) fail_now("unexpected_beat");
            else begin
               w = exp_w.pop_front();
               chk("wdata", wdata, w.data);
               chk("wlast", wlast, w.last);
            end
            beats_seen++;
            if (wlast) begin
               aw_done   = 0;
               b_pending = 1;
            end
         end
         if (bvalid && bready) begin
            b_hs = 1;
            exp_cnt++;
            exp_err = exp_err | (bresp != 2'b00);
            chk_after = 1;
         end
      end
   end

   task automatic do_reset_checks(input string tag);
      @(negedge clk);
      chk({tag, "_awvalid"}, awvalid, 0);
      chk({tag, "_wvalid"}, wvalid, 0);
      chk({tag, "_wlast"}, wlast, 0);
      chk({tag, "_bready"}, bready, 0);
      chk({tag, "_rd_en"}, fifo_rd_en, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_resp_err"}, resp_err, 0);
      chk({tag, "_awaddr"}, awaddr, 0);
      chk({tag, "_burst_cnt"}, burst_cnt, 0);
   endtask

   // Reference model: a burst of n beats goes to the current ring address.
   task automatic load(input int n, input logic [1:0] resp);
      logic [DW-1:0] d;
      aw_t a;
      w_t  w;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom();
         in_q.push_back(d);
         w.data = d;
         w.last = (i == n - 1);
         exp_w.push_back(w);
      end
      a.addr = AWD'(model_addr);
      a.len  = 8'(n - 1);
      exp_aw.push_back(a);
      model_addr = model_addr + n * BEAT;
      if (model_addr >= REGION) model_addr = 0;
      resp_q.push_back(resp);
      tick();
      tick();
   endtask

   task automatic run_burst(input int n, input logic [1:0] resp);
      int t;
      load(n, resp);
      flush  = (n < BL);
      enable = 1'b1;
      t = 0;
      while (!busy && t < 50) begin tick(); t++; end
      if (!busy) fail_now("launch_timeout");
      enable = 1'b0;
      flush  = 1'b0;
      t = 0;
      while (busy && t < 1000) begin tick(); t++; end
      if (busy) fail_now("burst_timeout");
      tick();
      tick();
   endtask

   initial begin
      int t;
      rstn = 1'b0; enable = 1'b0; flush = 1'b0;
      repeat (3) tick();
      do_reset_checks("reset");
      rstn = 1'b1;
      tick();

      run_burst(16, 2'b00);
      run_burst(16, 2'b10);
      run_burst(5, 2'b00);
      stall_mode = 1;
      repeat (4) run_burst(int'($urandom_range(1, 16)), 2'b00);
      stall_mode = 0;
      repeat (4) tick();
      chk("leftover_beats", exp_w.size(), 0);
      chk("leftover_aw", exp_aw.size(), 0);

      // Abandon a full burst partway through the data phase.
      load(16, 2'b00);
      beats_seen = 0;
      enable = 1'b1;
      t = 0;
      while (beats_seen < 7 && t < 200) begin tick(); t++; end
      if (beats_seen < 7) fail_now("beat7_timeout");
      rstn = 1'b0;
      enable = 1'b0;
      tick();
      do_reset_checks("midrst");
      exp_aw.delete(); exp_w.delete(); resp_q.delete();
      model_addr = 0; exp_cnt = 0; exp_err = 0;
      tick();
      rstn = 1'b1;

      while (fifo_q.size() + in_q.size() < 64) in_q.push_back({DW{1'b1}});
      repeat (30) begin
         @(negedge clk);
         chk("disabled_awvalid", awvalid, 0);
         chk("disabled_busy", busy, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
